// File: rtl/ws2812_multi_strip_driver.sv
// WS2812 multi-strip driver: NUM_STRIPS bit-aligned strips fed from one
// byte-wide frame memory with a 1-cycle-latency synchronous read port.
// Each byte is fetched for every strip while the previous byte is still
// being sent, so the data streams continue without gaps between bytes or LEDs.

// One output lane: a staging byte filled by the fetch sequencer, a shift
// register holding the byte currently on the wire, and the registered pin.
module ws2812_lane #(
   parameter int CNT_W = 5,
   parameter int T0H   = 6,
   parameter int T1H   = 13
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             cap_en,
   input  logic [7:0]       cap_data,
   input  logic             load,
   input  logic             shift,
   input  logic             active,
   input  logic [CNT_W-1:0] slot,
   output logic             line
);

   localparam logic [CNT_W-1:0] T0H_C = CNT_W'(T0H);
   localparam logic [CNT_W-1:0] T1H_C = CNT_W'(T1H);

   logic [7:0] staging;
   logic [7:0] shreg;
   logic [7:0] load_byte;
   logic       cur_bit;
   logic       hi;

   // Byte entering the shift register; the last strip's byte of the very first
   // fetch arrives on the same cycle it is needed, so it bypasses staging.
   always_comb begin
      load_byte = cap_en ? cap_data : staging;
      cur_bit   = load ? load_byte[7] : shreg[7];
      hi        = active && (slot < (cur_bit ? T1H_C : T0H_C));
   end

   // Staging capture, shift register and registered output pin.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         staging <= '0;
         shreg   <= '0;
         line    <= 1'b0;
      end else begin
         if (cap_en)
            staging <= cap_data;
         if (load)
            shreg <= load_byte;
         else if (shift)
            shreg <= {shreg[6:0], 1'b0};
         line <= hi;
      end
   end

endmodule

module ws2812_multi_strip_driver #(
   parameter int INPUT_CLOCK_FREQ_MHZ = 16,
   parameter int NUM_STRIPS           = 4,
   parameter int MAX_LEDS             = 64,
   parameter int BASE_ADDRESS         = 0,
   parameter int ADDR_WIDTH           = 13,
   parameter int T0H_NS               = 400,
   parameter int T1H_NS               = 800,
   parameter int BIT_NS               = 1250,
   parameter int RESET_US             = 60,
   localparam int LED_W               = $clog2(MAX_LEDS + 1)
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [LED_W-1:0]      num_leds,
   output logic                  busy,
   output logic                  frame_done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [7:0]            mem_data,
   output logic [NUM_STRIPS-1:0] strip_out
);

   localparam int F      = INPUT_CLOCK_FREQ_MHZ;
   localparam int T_BIT  = (BIT_NS * F + 500) / 1000;
   localparam int T0H    = (T0H_NS * F + 500) / 1000;
   localparam int T1H    = (T1H_NS * F + 500) / 1000;
   localparam int T_RST  = RESET_US * F;
   localparam int CNT_W  = $clog2(T_BIT + 1);
   localparam int RST_W  = $clog2(T_RST + 1);
   localparam int LANE_W = (NUM_STRIPS > 1) ? $clog2(NUM_STRIPS) : 1;

   localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_ADDRESS);
   localparam logic [ADDR_WIDTH-1:0] STRIDE = ADDR_WIDTH'(3 * MAX_LEDS);
   localparam logic [LED_W-1:0]      MAX_N  = LED_W'(MAX_LEDS);
   localparam logic [LANE_W-1:0]     LAST_L = LANE_W'(NUM_STRIPS - 1);

   generate
      if (NUM_STRIPS + 1 > 8 * T_BIT || T1H >= T_BIT || NUM_STRIPS < 1 || NUM_STRIPS > 16) begin : g_bad_cfg
         $error("ws2812_multi_strip_driver: unsupported timing/strip configuration");
      end
   endgenerate

   typedef enum logic [2:0] {IDLE, PREFETCH, SEND, LATCH, DONE} state_t;

   state_t              state, state_nxt;
   logic [LED_W-1:0]    n_leds;
   logic [LED_W-1:0]    n_clamp;
   logic [LED_W-1:0]    led_cnt;
   logic [1:0]          byte_cnt;
   logic [2:0]          bit_cnt;
   logic [CNT_W-1:0]    slot_cnt;
   logic [RST_W-1:0]    rst_cnt;
   logic [ADDR_WIDTH-1:0] nxt_addr;
   // vld_pipe[0]: read on the bus this cycle, vld_pipe[1]: its data on mem_data
   logic [1:0]          vld_pipe;
   logic [LANE_W-1:0]   rd_lane;
   logic [LANE_W-1:0]   cap_lane;

   logic accept, slot_end, last_led, last_byte, byte_end, pf_done;
   logic enter_byte, fetch_more, rst_end, load_now, shift_now, sending;

   // Frame-level events shared by the FSM, counters and fetch sequencer.
   always_comb begin
      n_clamp    = (num_leds > MAX_N) ? MAX_N : num_leds;
      accept     = (state == IDLE) && start;
      sending    = (state == SEND);
      slot_end   = (slot_cnt == CNT_W'(T_BIT - 1));
      last_led   = (led_cnt == n_leds - LED_W'(1));
      last_byte  = last_led && (byte_cnt == 2'd2);
      byte_end   = sending && slot_end && (bit_cnt == 3'd0);
      pf_done    = (state == PREFETCH) && vld_pipe[0] && (rd_lane == LAST_L);
      enter_byte = pf_done || (byte_end && !last_byte);
      // The byte being entered is the final one when leaving byte 1 of the last LED.
      fetch_more = (state == PREFETCH) || !(last_led && (byte_cnt == 2'd1));
      rst_end    = (state == LATCH) && (rst_cnt == RST_W'(T_RST - 1));
      load_now   = sending && (bit_cnt == 3'd7) && (slot_cnt == '0);
      shift_now  = sending && slot_end;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start) state_nxt = (n_clamp == '0) ? LATCH : PREFETCH;
         PREFETCH: if (pf_done) state_nxt = SEND;
         SEND:     if (byte_end && last_byte) state_nxt = LATCH;
         LATCH:    if (rst_end) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      busy       = 1'b0;
      frame_done = 1'b0;
      case (state)
         PREFETCH, SEND, LATCH: busy = 1'b1;
         DONE:                  frame_done = 1'b1;
         default: ;
      endcase
   end

   // Bit-slot, bit, byte, LED and latch counters.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         n_leds   <= '0;
         led_cnt  <= '0;
         byte_cnt <= '0;
         bit_cnt  <= '0;
         slot_cnt <= '0;
         rst_cnt  <= '0;
      end else begin
         if (accept) begin
            n_leds   <= n_clamp;
            led_cnt  <= '0;
            byte_cnt <= '0;
         end else if (byte_end && !last_byte) begin
            if (byte_cnt == 2'd2) begin
               byte_cnt <= '0;
               led_cnt  <= led_cnt + LED_W'(1);
            end else begin
               byte_cnt <= byte_cnt + 2'd1;
            end
         end

         if (enter_byte) begin
            slot_cnt <= '0;
            bit_cnt  <= 3'd7;
         end else if (sending) begin
            if (slot_end) begin
               slot_cnt <= '0;
               bit_cnt  <= bit_cnt - 3'd1;
            end else begin
               slot_cnt <= slot_cnt + CNT_W'(1);
            end
         end

         rst_cnt <= (state == LATCH) ? rst_cnt + RST_W'(1) : '0;
      end
   end

   // Fetch sequencer: one read per strip on consecutive cycles. Strip 0 of
   // consecutive wire bytes is contiguous, so the next byte is always +1.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         mem_addr <= BASE_A;
         nxt_addr <= '0;
         vld_pipe <= '0;
         rd_lane  <= '0;
         cap_lane <= '0;
      end else begin
         vld_pipe[1] <= vld_pipe[0];
         cap_lane    <= rd_lane;
         if (accept && (n_clamp != '0)) begin
            mem_addr    <= BASE_A;
            nxt_addr    <= BASE_A + ADDR_WIDTH'(1);
            vld_pipe[0] <= 1'b1;
            rd_lane     <= '0;
         end else if (enter_byte && fetch_more) begin
            mem_addr    <= nxt_addr;
            nxt_addr    <= nxt_addr + ADDR_WIDTH'(1);
            vld_pipe[0] <= 1'b1;
            rd_lane     <= '0;
         end else if (vld_pipe[0]) begin
            if (rd_lane == LAST_L) begin
               vld_pipe[0] <= 1'b0;
            end else begin
               rd_lane  <= rd_lane + LANE_W'(1);
               mem_addr <= mem_addr + STRIDE;
            end
         end
      end
   end

   // Per-strip lanes.
   generate
      for (genvar s = 0; s < NUM_STRIPS; s++) begin : g_lane
         ws2812_lane #(
            .CNT_W (CNT_W),
            .T0H   (T0H),
            .T1H   (T1H)
         ) u_lane (
            .clk      (clk),
            .resetn   (resetn),
            .cap_en   (vld_pipe[1] && (cap_lane == LANE_W'(s))),
            .cap_data (mem_data),
            .load     (load_now),
            .shift    (shift_now),
            .active   (sending),
            .slot     (slot_cnt),
            .line     (strip_out[s])
         );
      end
   endgenerate

endmodule

// File: tb/tb_ws2812_multi_strip_driver.sv
// Bench for ws2812_multi_strip_driver: DUT A (2 strips, 3 LEDs, base 0) and
// DUT B (4 strips, 8 LEDs, base 100) on a shared clock, each with its own
// 1-cycle-latency memory model. A line monitor decodes pulses into bytes.
module tb_ws2812_multi_strip_driver;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic start_a = 1'b0, start_b = 1'b0;
   logic [1:0] nl_a = '0;
   logic [3:0] nl_b = '0;
   logic busy_a, done_a, busy_b, done_b;
   logic [12:0] maddr_a, maddr_b;
   logic [7:0] mdata_a, mdata_b;
   logic [1:0] so_a;
   logic [3:0] so_b;
   logic [7:0] memA [0:8191];
   logic [7:0] memB [0:8191];
   wire  [5:0] lines = {so_b, so_a};

   always #5 clk = ~clk;

   ws2812_multi_strip_driver #(.NUM_STRIPS(2), .MAX_LEDS(3), .BASE_ADDRESS(0)) dut_a (
      .clk(clk), .resetn(resetn), .start(start_a), .num_leds(nl_a), .busy(busy_a),
      .frame_done(done_a), .mem_addr(maddr_a), .mem_data(mdata_a), .strip_out(so_a));

   ws2812_multi_strip_driver #(.NUM_STRIPS(4), .MAX_LEDS(8), .BASE_ADDRESS(100)) dut_b (
      .clk(clk), .resetn(resetn), .start(start_b), .num_leds(nl_b), .busy(busy_b),
      .frame_done(done_b), .mem_addr(maddr_b), .mem_data(mdata_b), .strip_out(so_b));

   always @(posedge clk) begin
      mdata_a <= memA[maddr_a];
      mdata_b <= memB[maddr_b];
   end

   // ---------------- line monitor ----------------
   bit         mon_clr = 1'b1;
   int         ncyc = 0;
   int         hi_len [6];
   bit         prev [6];
   int         last_rise [6];
   int         nbits [6];
   logic [7:0] acc [6];
   logic [7:0] rx [6][24];
   int         pulse_bad, period_bad, achg_a, achg_b;
   logic [12:0] pa, pb;

   initial begin : mon
      forever begin
         @(negedge clk);
         ncyc++;
         if (mon_clr) begin
            for (int l = 0; l < 6; l++) begin
               hi_len[l] = 0; prev[l] = 0; last_rise[l] = -1; nbits[l] = 0; acc[l] = '0;
            end
            pulse_bad = 0; period_bad = 0; achg_a = 0; achg_b = 0;
            pa = maddr_a; pb = maddr_b;
         end else begin
            if (maddr_a != pa) achg_a++;
            if (maddr_b != pb) achg_b++;
            pa = maddr_a; pb = maddr_b;
            for (int l = 0; l < 6; l++) begin
               if (lines[l]) begin
                  if (!prev[l]) begin
                     if (last_rise[l] >= 0 && ncyc - last_rise[l] != 20) period_bad++;
                     last_rise[l] = ncyc;
                  end
                  hi_len[l]++;
               end else if (prev[l]) begin
                  if (hi_len[l] != 6 && hi_len[l] != 13) pulse_bad++;
                  acc[l] = {acc[l][6:0], hi_len[l] >= 10};
                  nbits[l]++;
                  if (nbits[l] % 8 == 0 && nbits[l] / 8 <= 24) rx[l][nbits[l] / 8 - 1] = acc[l];
                  hi_len[l] = 0;
               end
               prev[l] = lines[l];
            end
         end
      end
   end

   // ---------------- checking ----------------
   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Runs one frame on DUT A (sel=0) or B (sel=1). With poke set, start is
   // pulsed mid-frame and again in the frame_done cycle.
   task automatic run_frame(input bit sel, input int nl, input bit poke,
                            output int len, output bit busy1, output bit busy_after);
      mon_clr = 1'b1;
      repeat (3) @(negedge clk);
      mon_clr = 1'b0;
      @(negedge clk);
      if (sel) begin nl_b = nl[3:0]; start_b = 1'b1; end
      else     begin nl_a = nl[1:0]; start_a = 1'b1; end
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      nl_a = 2'd3; nl_b = 4'd1;          // changes after acceptance must not matter
      len = 1;
      busy1 = sel ? busy_b : busy_a;
      while (!(sel ? done_b : done_a) && len < 6000) begin
         if (sel) start_b = poke && (len == 300);
         else     start_a = poke && (len == 300);
         @(negedge clk);
         len++;
      end
      if (sel) start_b = poke; else start_a = poke;
      @(negedge clk);
      start_a = 1'b0; start_b = 1'b0;
      busy_after = sel ? busy_b : busy_a;
   endtask

   task automatic check_bytes(input bit sel, input int leds, input string tag);
      int nstr, l0, maxl, base, mism, e;
      nstr = sel ? 4 : 2; l0 = sel ? 2 : 0; maxl = sel ? 8 : 3; base = sel ? 100 : 0;
      for (int s = 0; s < nstr; s++) begin
         mism = 0;
         for (int k = 0; k < 3 * leds && k < 24; k++) begin
            e = sel ? memB[base + (s * maxl + k / 3) * 3 + k % 3] : memA[base + (s * maxl + k / 3) * 3 + k % 3];
            if (rx[l0 + s][k] !== e[7:0]) mism++;
         end
         chk($sformatf("%s bits strip%0d", tag, s), nbits[l0 + s], 24 * leds);
         chk($sformatf("%s byte mismatches strip%0d", tag, s), mism, 0);
      end
   endtask

   typedef struct {
      bit sel;
      int nl;
      int exp_len;
      int exp_leds;
      bit poke;
   } vec_t;

   initial begin : main
      vec_t vecs[8];
      int len, w;
      bit b1, ba;
      logic [31:0] r;

      // Frame lengths: (N+1) + n*480 + 960, or 961 when n=0.
      vecs[0] = '{0, 1, 1443, 1, 0};
      vecs[1] = '{0, 3, 2403, 3, 1};
      vecs[2] = '{0, 0,  961, 0, 0};
      vecs[3] = '{0, 2, 1923, 2, 0};
      vecs[4] = '{1, 8, 4805, 8, 0};
      vecs[5] = '{1, 9, 4805, 8, 0};   // clamped to MAX_LEDS
      vecs[6] = '{1, 0,  961, 0, 1};
      vecs[7] = '{1, 2, 1925, 2, 0};

      for (int i = 0; i < 8192; i++) begin memA[i] = 8'h00; memB[i] = 8'h00; end
      memA[0] = 8'hFF; memA[1] = 8'h00; memA[2] = 8'hA5;
      memA[3] = 8'h12; memA[4] = 8'h34; memA[5] = 8'h56;
      memA[6] = 8'h80; memA[7] = 8'h01; memA[8] = 8'hC3;
      memA[9] = 8'h00; memA[10] = 8'hFF; memA[11] = 8'h5A;
      memA[12] = 8'h9A; memA[13] = 8'hBC; memA[14] = 8'hDE;
      memA[15] = 8'h7E; memA[16] = 8'hE7; memA[17] = 8'h3C;
      for (int i = 100; i < 100 + 96; i++) begin r = $urandom; memB[i] = r[7:0]; end

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset strip_a", so_a, 0);
      chk("reset strip_b", so_b, 0);
      chk("reset busy", {busy_a, busy_b}, 0);
      chk("reset frame_done", {done_a, done_b}, 0);
      chk("reset mem_addr_a", maddr_a, 0);
      chk("reset mem_addr_b", maddr_b, 100);
      resetn = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_frame(vecs[i].sel, vecs[i].nl, vecs[i].poke, len, b1, ba);
         chk($sformatf("v%0d frame length", i), len, vecs[i].exp_len);
         chk($sformatf("v%0d busy after start", i), b1, 1);
         chk($sformatf("v%0d busy after frame_done", i), ba, 0);
         chk($sformatf("v%0d pulse widths", i), pulse_bad, 0);
         chk($sformatf("v%0d bit periods", i), period_bad, 0);
         check_bytes(vecs[i].sel, vecs[i].exp_leds, $sformatf("v%0d", i));
         if (vecs[i].exp_leds == 0)
            chk($sformatf("v%0d no reads", i), vecs[i].sel ? achg_b : achg_a, 0);
         if (i == 0) begin
            chk("first LED strip0", {rx[0][0], rx[0][1], rx[0][2]}, 24'hFF00A5);
            chk("first LED strip1", {rx[1][0], rx[1][1], rx[1][2]}, 24'h00FF5A);
         end
      end

      // Reset mid-bit while a line is high
      mon_clr = 1'b1;
      @(negedge clk);
      nl_a = 2'd1; start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      w = 0;
      while (!so_a[0] && w < 60) begin @(negedge clk); w++; end
      chk("abort line high before reset", so_a[0], 1);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      chk("abort strip_out", so_a, 0);
      chk("abort busy", busy_a, 0);
      chk("abort frame_done", done_a, 0);
      chk("abort mem_addr", maddr_a, 0);
      run_frame(0, 1, 0, len, b1, ba);
      chk("post-abort frame length", len, 1443);
      chk("post-abort pulse widths", pulse_bad, 0);
      chk("post-abort strip0", {rx[0][0], rx[0][1], rx[0][2]}, 24'hFF00A5);
      chk("post-abort strip1", {rx[1][0], rx[1][1], rx[1][2]}, 24'h00FF5A);
      chk("post-abort bits", nbits[0] + nbits[1], 48);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
